// File: rtl/lcd_char_buffer.sv
// 2x16 character store feeding the SC1602 LCD driver: host write port, driver
// read port with one-cycle latency, fill-on-reset/clear, and a frame-request flag.
module lcd_char_buffer #(
  parameter logic [7:0]  FILL_CHAR      = 8'h20,
  parameter logic [23:0] REFRESH_CYCLES = 24'd100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       clear,
  input  logic       rd,
  input  logic [4:0] addr,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_req,
  input  logic       frame_ack,
  output logic       busy
);

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned TIMER_W = 24;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] IDLE = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic              fill_done;
  logic [ADDR_W-1:0] fill_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_fire;
  logic              dirty;
  logic [TIMER_W-1:0] timer;

  // A clear in the same cycle masks the handshake, so it always beats a write.
  assign wr_ready = (state == IDLE) && !clear;
  assign busy     = (state == FILL);
  assign wr_fire  = wr_valid && wr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fill_done  = 1'b0;
    case (state)
      FILL: begin
        if (!clear && fill_idx == ADDR_W'(DEPTH - 1)) begin
          state_next = IDLE;
          fill_done  = 1'b1;
        end
      end
      IDLE: begin
        if (clear) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               fill_idx <= '0;
    else if (clear)          fill_idx <= '0;
    else if (state == FILL)  fill_idx <= fill_idx + ADDR_W'(1);
  end

  // Storage array; fill and host writes are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (state == FILL)  mem[fill_idx] <= FILL_CHAR;
    else if (wr_fire)   mem[wr_addr]  <= wr_data;
  end

  // Read port samples the pre-write contents on a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data       <= FILL_CHAR;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd;
      if (rd) data <= mem[addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty     <= 1'b0;
      timer     <= '0;
      frame_req <= 1'b0;
    end else begin
      if (wr_fire || fill_done) dirty <= 1'b1;
      else if (frame_ack)       dirty <= 1'b0;

      if (frame_ack)                    timer <= '0;
      else if (timer != REFRESH_CYCLES) timer <= timer + TIMER_W'(1);

      frame_req <= !frame_ack && dirty && (timer == REFRESH_CYCLES);
    end
  end

endmodule

// File: tb/tb_lcd_char_buffer.sv
// Directed bench for lcd_char_buffer: vector table for the read/write port plus
// hand sequences for fill, clear, frame handshake and asynchronous reset.
module tb_lcd_char_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       clear;
  logic       rd;
  logic [4:0] addr;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_req;
  logic       frame_ack;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  lcd_char_buffer #(
    .FILL_CHAR     (8'h20),
    .REFRESH_CYCLES(24'd50)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear     (clear),
    .rd        (rd),
    .addr      (addr),
    .data      (data),
    .data_valid(data_valid),
    .frame_req (frame_req),
    .frame_ack (frame_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rd;
    logic [4:0] addr;
    logic       wv;
    logic [4:0] wa;
    logic [7:0] wd;
    logic       ready;
    logic       dv;
    logic [7:0] data;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [4:0] a, input logic [7:0] e, input string n);
    rd = 1'b1;
    addr = a;
    tick();
    rd = 1'b0;
    chk(n, 32'(data), 32'(e));
    chk({n, "_dv"}, 32'(data_valid), 32'd1);
  endtask

  task automatic fill_chk(input string n);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk({n, "_busy"}, 32'(busy), 32'(k < 32));
      chk({n, "_ready"}, 32'(wr_ready), 32'(k == 32));
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b0, 5'h00, 1'b1, 5'h00, 8'h48, 1'b1, 1'b0, 8'h20};
    tbl[1]  = '{1'b0, 5'h00, 1'b1, 5'h1F, 8'h69, 1'b1, 1'b0, 8'h20};
    tbl[2]  = '{1'b1, 5'h00, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 8'h48};
    tbl[3]  = '{1'b1, 5'h1F, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 8'h69};
    tbl[4]  = '{1'b0, 5'h00, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 8'h69};
    tbl[5]  = '{1'b1, 5'h05, 1'b1, 5'h05, 8'h41, 1'b1, 1'b1, 8'h20};
    tbl[6]  = '{1'b1, 5'h05, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 8'h41};
    tbl[7]  = '{1'b0, 5'h00, 1'b1, 5'h0F, 8'h31, 1'b1, 1'b0, 8'h41};
    tbl[8]  = '{1'b1, 5'h0F, 1'b1, 5'h10, 8'h32, 1'b1, 1'b1, 8'h31};
    tbl[9]  = '{1'b1, 5'h10, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 8'h32};
    tbl[10] = '{1'b1, 5'h11, 1'b1, 5'h11, 8'h7E, 1'b1, 1'b1, 8'h20};

    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clear = 1'b0; rd = 1'b0; addr = '0; frame_ack = 1'b0;

    tick();
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_data", 32'(data), 32'h20);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_frame_req", 32'(frame_req), 32'd0);
    tick();
    reset = 1'b0;

    fill_chk("init_fill");

    // Edges 33..64: read everything back while watching frame_req rise at 51
    for (int i = 0; i < 32; i++) begin
      rd = 1'b1;
      addr = 5'(i);
      tick();
      chk($sformatf("init_rd%0d", i), 32'(data), 32'h20);
      chk($sformatf("init_dv%0d", i), 32'(data_valid), 32'd1);
      chk($sformatf("init_req_e%0d", 33 + i), 32'(frame_req), 32'(33 + i >= 51));
    end
    rd = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rd = tbl[i].rd; addr = tbl[i].addr;
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(wr_ready), 32'(tbl[i].ready));
      tick();
      chk($sformatf("tbl%0d_dv", i), 32'(data_valid), 32'(tbl[i].dv));
      chk($sformatf("tbl%0d_data", i), 32'(data), 32'(tbl[i].data));
    end
    rd = 1'b0; wr_valid = 1'b0;

    // Ack together with an accepted write: dirty survives, request re-arms
    chk("preack_req", 32'(frame_req), 32'd1);
    frame_ack = 1'b1; wr_valid = 1'b1; wr_addr = 5'h02; wr_data = 8'h58;
    #1;
    chk("ackwr_ready", 32'(wr_ready), 32'd1);
    tick();
    frame_ack = 1'b0; wr_valid = 1'b0;
    chk("ackwr_req_drop", 32'(frame_req), 32'd0);
    for (int j = 1; j <= 51; j++) begin
      tick();
      chk($sformatf("ackwr_req_j%0d", j), 32'(frame_req), 32'(j == 51));
    end
    read_chk(5'h02, 8'h58, "ackwr_rd02");

    // Ack with no write: request stays low
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("ack_req_drop", 32'(frame_req), 32'd0);
    for (int j = 1; j <= 120; j++) begin
      tick();
      if (j % 20 == 0) chk($sformatf("ack_req_low_j%0d", j), 32'(frame_req), 32'd0);
    end

    // Clear beats a simultaneous write; second clear at fill index 10 restarts
    clear = 1'b1; wr_valid = 1'b1; wr_addr = 5'h07; wr_data = 8'h55;
    #1;
    chk("clr_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    clear = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk($sformatf("clr1_busy_j%0d", j), 32'(busy), 32'd1);
      chk($sformatf("clr1_ready_j%0d", j), 32'(wr_ready), 32'd0);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    chk("clr2_busy", 32'(busy), 32'd1);
    fill_chk("clr2_fill");
    tick();
    chk("clr2_req", 32'(frame_req), 32'd1);
    read_chk(5'h07, 8'h20, "clr_rd07");
    read_chk(5'h00, 8'h20, "clr_rd00");
    read_chk(5'h1F, 8'h20, "clr_rd1f");
    read_chk(5'h05, 8'h20, "clr_rd05");

    // Asynchronous reset in the middle of a fill
    wr_valid = 1'b1; wr_addr = 5'h03; wr_data = 8'h77;
    tick();
    wr_valid = 1'b0;
    read_chk(5'h03, 8'h77, "pre_rd03");
    wr_valid = 1'b1; wr_addr = 5'h1F; wr_data = 8'h69;
    tick();
    wr_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (19) tick();
    rd = 1'b1; addr = 5'h1F;
    tick();
    rd = 1'b0;
    chk("prerst_data", 32'(data), 32'h69);
    chk("prerst_req", 32'(frame_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_wr_ready", 32'(wr_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    chk("arst_data", 32'(data), 32'h20);
    chk("arst_dv", 32'(data_valid), 32'd0);
    chk("arst_frame_req", 32'(frame_req), 32'd0);
    tick();
    reset = 1'b0;
    fill_chk("arst_fill");
    for (int i = 0; i < 32; i++) begin
      read_chk(5'(i), 8'h20, $sformatf("arst_rd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
